ram8_seq: RTL and testbench

- Sequencer that sits directly upstream of ram8 and drives its in/addr/load inputs.
- FILL mode: accepts a stream of 16-bit words over a valid/ready handshake and writes them to consecutive addresses 0..DEPTH-1.
- DUMP mode: walks addresses 0..DEPTH-1 and streams ram8's out back over a valid/ready handshake.
- Replaces hand-sequenced addr/load/clk stimulus with a reusable bulk load/readback engine.

---
 rtl/ram8_seq_pkg.sv | 13 +
 rtl/ram8_seq.sv | 94 +++++++++
 tb/tb_ram8_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram8_seq_pkg.sv
// Shared constants for the ram8 bulk fill/readback sequencer.
// State encoding is kept as plain localparams so older code can compare against raw values.
package ram8_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DUMP = 2'd2;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_AW    = 3;
  localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/ram8_seq.sv
// Bulk load / readback engine sitting directly upstream of ram8.
// FILL streams words into addresses 0..DEPTH-1; DUMP streams them back out.
module ram8_seq
  import ram8_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AW    = DEFAULT_AW,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_fill,
  input  logic             start_dump,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [WIDTH-1:0] ram_in,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_load,
  input  logic [WIDTH-1:0] ram_out,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]    state;
  logic [AW-1:0] ptr;
  logic          at_last;

  assign at_last = (ptr == LAST_ADDR);

  // The terminal compare is the only wrap mechanism, so ptr never reaches
  // addresses at or above DEPTH even when DEPTH < 2**AW.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_fill) begin
            state <= ST_FILL;
            ptr   <= '0;
          end else if (start_dump) begin
            state <= ST_DUMP;
            ptr   <= '0;
          end
        end
        ST_FILL: begin
          if (in_valid) begin
            if (at_last) begin
              state <= ST_IDLE;
              ptr   <= '0;
              done  <= 1'b1;
            end else begin
              ptr <= ptr + AW'(1);
            end
          end
        end
        ST_DUMP: begin
          if (dump_ready) begin
            if (at_last) begin
              state <= ST_IDLE;
              ptr   <= '0;
              done  <= 1'b1;
            end else begin
              ptr <= ptr + AW'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

  // ram_load ignores reset on purpose: a write presented while still in FILL lands.
  assign ram_addr   = ptr;
  assign ram_in     = in_data;
  assign ram_load   = (state == ST_FILL) & in_valid;
  assign in_ready   = (state == ST_FILL);
  assign dump_valid = (state == ST_DUMP);
  assign dump_data  = ram_out;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_ram8_seq.sv
// Self-checking bench for ram8_seq: a behavioural ram8 harness, a transaction-level
// model compared every cycle, and directed vectors with literal expectations.
module tb_ram8_seq;

  logic        clk;
  logic        reset;
  logic        start_fill;
  logic        start_dump;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dump_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [15:0] ram_in;
  logic [2:0]  ram_addr;
  logic        ram_load;
  logic [15:0] ram_out;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;

  logic [15:0] fill_words [8];
  logic [15:0] ram_mem [8];
  logic [15:0] model_mem [8];

  // model state: op is 0 idle, 1 filling, 2 dumping; words counts transfers in the op
  int  op;
  int  words;
  bit  exp_done;
  bit  model_live;

  ram8_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start_fill(start_fill),
    .start_dump(start_dump),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dump_data (dump_data),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .ram_in    (ram_in),
    .ram_addr  (ram_addr),
    .ram_load  (ram_load),
    .ram_out   (ram_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ram8 stand-in: write on the rising edge, combinational read
  always @(posedge clk) begin
    if (ram_load) ram_mem[ram_addr] <= ram_in;
  end
  assign ram_out = ram_mem[ram_addr];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // transaction-level model of one sequencer operation
  always @(posedge clk) begin
    if (op == 1 && in_valid) model_mem[words] = in_data;
    exp_done = 1'b0;
    if (reset) begin
      op = 0;
      words = 0;
      model_live = 1'b1;
    end else if (op == 0) begin
      words = 0;
      if (start_fill) op = 1;
      else if (start_dump) op = 2;
    end else if ((op == 1 && in_valid) || (op == 2 && dump_ready)) begin
      words++;
      if (words == 8) begin
        op = 0;
        words = 0;
        exp_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check_output("busy", busy, op != 0);
      check_output("in_ready", in_ready, op == 1);
      check_output("dump_valid", dump_valid, op == 2);
      check_output("ram_load", ram_load, (op == 1) && in_valid);
      check_output("ram_addr", ram_addr, words);
      check_output("ram_in", ram_in, in_data);
      check_output("done", done, exp_done);
      if (op == 2) check_output("dump_data", dump_data, model_mem[words]);
    end
  end

  task automatic apply_stimulus();
    // reset and idle
    reset = 1'b1;
    tick();
    tick();
    check_output("rst_busy", busy, 0);
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_dump_valid", dump_valid, 0);
    check_output("rst_ram_load", ram_load, 0);
    check_output("rst_ram_addr", ram_addr, 0);
    check_output("rst_done", done, 0);
    reset = 1'b0;
    tick();

    // back-to-back fill
    start_fill = 1'b1;
    tick();
    start_fill = 1'b0;
    check_output("fill_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      in_data  = fill_words[i];
      in_valid = 1'b1;
      #1;
      check_output("fill_load", ram_load, 1);
      check_output("fill_addr", ram_addr, i);
      tick();
    end
    in_valid = 1'b0;
    check_output("fill_done", done, 1);
    check_output("fill_busy_low", busy, 0);
    tick();
    check_output("fill_done_once", done, 0);

    // full-rate dump
    start_dump = 1'b1;
    dump_ready = 1'b1;
    tick();
    start_dump = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_output("dump_word", dump_data, fill_words[i]);
      check_output("dump_addr", ram_addr, i);
      tick();
    end
    check_output("dump_done", done, 1);
    dump_ready = 1'b0;
    tick();

    // dump stalled at address 4
    start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    dump_ready = 1'b1;
    repeat (4) tick();
    dump_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output("stall_data", dump_data, 16'h0F0F);
      check_output("stall_addr", ram_addr, 4);
      tick();
    end
    dump_ready = 1'b1;
    repeat (4) tick();
    check_output("stall_dump_done", done, 1);
    dump_ready = 1'b0;
    tick();

    // both starts at once: fill wins; later start_dump ignored; bubbles hold the address
    start_fill = 1'b1;
    start_dump = 1'b1;
    tick();
    start_fill = 1'b0;
    start_dump = 1'b0;
    check_output("both_in_ready", in_ready, 1);
    check_output("both_dump_valid", dump_valid, 0);
    for (int k = 0; k < 15; k++) begin
      in_valid   = (k % 2 == 0);
      in_data    = fill_words[k / 2];
      start_dump = (k == 3);
      #1;
      check_output("bubble_addr", ram_addr, (k + 1) / 2);
      check_output("bubble_load", ram_load, (k % 2 == 0));
      tick();
    end
    in_valid   = 1'b0;
    start_dump = 1'b0;
    check_output("bubble_done", done, 1);
    check_output("bubble_no_dump", dump_valid, 0);
    tick();

    // reset at ptr 5 during fill
    start_fill = 1'b1;
    tick();
    start_fill = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data  = 16'hA000 + 16'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    check_output("abort_addr_before", ram_addr, 5);
    tick();
    reset = 1'b0;
    check_output("abort_busy", busy, 0);
    check_output("abort_addr", ram_addr, 0);
    check_output("abort_no_done", done, 0);
    tick();
    check_output("abort_no_done_later", done, 0);

    start_dump = 1'b1;
    dump_ready = 1'b1;
    tick();
    start_dump = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_output("abort_dump_word", dump_data, (i < 5) ? 16'hA000 + 16'(i) : fill_words[i]);
      tick();
    end
    check_output("abort_dump_done", done, 1);
    dump_ready = 1'b0;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    op          = 0;
    words       = 0;
    exp_done    = 1'b0;
    model_live  = 1'b0;
    reset       = 1'b1;
    start_fill  = 1'b0;
    start_dump  = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    dump_ready  = 1'b0;
    fill_words  = '{16'h0000, 16'hFFFF, 16'h00FF, 16'hFF00,
                    16'h0F0F, 16'hF0F0, 16'h3333, 16'hCCCC};
    for (int i = 0; i < 8; i++) begin
      ram_mem[i]   = 16'h5A00 + 16'(i);
      model_mem[i] = 16'h5A00 + 16'(i);
    end
    apply_stimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
